div_rr_sched: RTL and testbench

//  Iterative restoring divider shared between two requesters via round-robin arbitration.

---
 rtl/div_rr_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_div_rr_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_rr_sched.sv
// div_rr_sched
//   Iterative restoring divider (one quotient bit per clock) shared by two
//   requesters through a round-robin arbiter. Returns quotient, remainder and a
//   divide-by-zero flag, all registered and held until the next done pulse.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   req0/a0/b0      requester 0: request, dividend, divisor (held until gnt0)
//   req1/a1/b1      requester 1: request, dividend, divisor (held until gnt1)
//   gnt0/gnt1       combinational accept strobes, only ever asserted in IDLE
//   busy            high while a divide is in RUN or DONE
//   done            one-cycle pulse, results valid
//   done_id         requester that owns the current results
//   quotient        registered quotient
//   remainder       registered remainder
//   div_zero        registered, set when the divisor was zero
module div_rr_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Working registers of the divide in progress
  logic [WIDTH-1:0]  r_a;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]  r_b;        // divisor
  logic [WIDTH-1:0]  r_p;        // partial remainder
  logic [CW-1:0]     r_cnt;      // step counter
  logic              r_id;       // owner of the divide in progress
  logic              r_last;     // last requester granted

  // Result registers
  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_div_zero;
  logic              r_done_id;

  // Arbitration
  logic              w_any;
  logic              w_gid;
  logic [WIDTH-1:0]  w_sel_a;
  logic [WIDTH-1:0]  w_sel_b;
  logic              w_b_zero;

  // One restoring step
  logic [WIDTH:0]    w_p_sh;
  logic [WIDTH:0]    w_t;
  logic [WIDTH-1:0]  w_p_nxt;
  logic [WIDTH-1:0]  w_a_sh;
  logic              w_last_step;

  // -------------------------------------------------------------------------
  // Arbitration: a lone request wins; with both pending the requester that
  // was not granted last wins. r_last resets to 1 so req0 wins first.
  // -------------------------------------------------------------------------
  always_comb begin
    w_any    = req0 | req1;
    w_gid    = (req0 & req1) ? ~r_last : req1;
    w_sel_a  = w_gid ? a1 : a0;
    w_sel_b  = w_gid ? b1 : b0;
    w_b_zero = (w_sel_b == '0);
  end

  // -------------------------------------------------------------------------
  // Restoring step. The shifted partial remainder and the trial difference
  // are WIDTH+1 bits so a divisor with its MSB set cannot overflow. The
  // stored remainder is always below the divisor, so it is kept at WIDTH
  // bits; its top bit would be constant zero.
  // -------------------------------------------------------------------------
  always_comb begin
    w_p_sh      = {r_p, r_a[WIDTH-1]};
    w_t         = w_p_sh - {1'b0, r_b};
    w_p_nxt     = w_t[WIDTH] ? w_p_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
    w_a_sh      = {r_a[WIDTH-2:0], ~w_t[WIDTH]};
    w_last_step = (r_cnt == LAST);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = w_b_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_step) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Grants are masked during the reset cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && w_any) begin
          gnt0 = ~w_gid;
          gnt1 = w_gid;
        end
      end
      S_RUN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath. Results are loaded on the edge that enters DONE so they change
  // only together with the done pulse and are held until the next one.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_done_id   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a    <= w_sel_a;
            r_b    <= w_sel_b;
            r_p    <= '0;
            r_cnt  <= '0;
            r_id   <= w_gid;
            r_last <= w_gid;
            if (w_b_zero) begin
              r_quotient  <= '1;
              r_remainder <= w_sel_a;
              r_div_zero  <= 1'b1;
              r_done_id   <= w_gid;
            end
          end
        end
        S_RUN: begin
          r_a   <= w_a_sh;
          r_p   <= w_p_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last_step) begin
            r_quotient  <= w_a_sh;
            r_remainder <= w_p_nxt;
            r_div_zero  <= 1'b0;
            r_done_id   <= r_id;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign done_id   = r_done_id;

endmodule

// File: tb/tb_div_rr_sched.sv
// tb_div_rr_sched
//   Directed bench for div_rr_sched at WIDTH=4: reset state, a table of single
//   requester divides, round-robin alternation, reset during RUN, and a sweep
//   of all 256 operand pairs against a behavioural reference.
module tb_div_rr_sched;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic       done;
  logic       done_id;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  div_rr_sched #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one request from a negedge, waits (bounded) for its grant and its
  // done pulse. Returns at the negedge of the DONE cycle.
  task automatic run_txn(input logic sel, input logic [3:0] a, input logic [3:0] b,
                         output logic gok, output int lat, output logic [3:0] q,
                         output logic [3:0] rm, output logic dz, output logic did);
    int g;
    bit got;
    bit fin;
    gok = 1'b0; lat = -1; q = '0; rm = '0; dz = 1'b0; did = 1'b0;
    g = 0; got = 1'b0; fin = 1'b0;
    if (sel) begin req1 = 1'b1; a1 = a; b1 = b; end
    else     begin req0 = 1'b1; a0 = a; b0 = b; end
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (gnt0 || gnt1) begin
        got = 1'b1;
        g   = cyc;
        gok = sel ? (gnt1 && !gnt0) : (gnt0 && !gnt1);
      end else begin
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    if (got) begin
      for (int k = 0; k < 20 && !fin; k++) begin
        @(negedge clk);
        if (done) begin
          fin = 1'b1;
          lat = cyc - g;
          q   = quotient;
          rm  = remainder;
          dz  = div_zero;
          did = done_id;
        end
      end
    end else begin
      @(negedge clk);
    end
  endtask

  logic       t_gok;
  int         t_lat;
  logic [3:0] t_q;
  logic [3:0] t_r;
  logic       t_dz;
  logic       t_id;
  logic [3:0] exp_q [3];
  logic [3:0] exp_r [3];
  logic       exp_id [3];

  initial begin
    vecs[0] = '{1'b0, 4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 5};
    vecs[1] = '{1'b1, 4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1};
    vecs[2] = '{1'b1, 4'd14, 4'd9,  4'd1,  4'd5, 1'b0, 5};
    vecs[3] = '{1'b1, 4'd7,  4'd9,  4'd0,  4'd7, 1'b0, 5};
    vecs[4] = '{1'b0, 4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
    vecs[5] = '{1'b0, 4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5};
    vecs[6] = '{1'b1, 4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
    vecs[7] = '{1'b0, 4'd8,  4'd0,  4'd15, 4'd8, 1'b1, 1};
    vecs[8] = '{1'b0, 4'd0,  4'd0,  4'd15, 4'd0, 1'b1, 1};

    // Reset with a request held: no grant during reset, all outputs clear.
    rst = 1'b1; req0 = 1'b1; a0 = 4'd5; b0 = 4'd1; req1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_div_zero", div_zero, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    rst = 1'b0; req0 = 1'b0;

    // Table of single-requester divides.
    foreach (vecs[i]) begin
      run_txn(vecs[i].sel, vecs[i].a, vecs[i].b, t_gok, t_lat, t_q, t_r, t_dz, t_id);
      check($sformatf("vec%0d_gnt", i), t_gok, 1);
      check($sformatf("vec%0d_latency", i), t_lat, vecs[i].lat);
      check($sformatf("vec%0d_quotient", i), t_q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), t_r, vecs[i].r);
      check($sformatf("vec%0d_div_zero", i), t_dz, vecs[i].dz);
      check($sformatf("vec%0d_done_id", i), t_id, vecs[i].sel);
      check($sformatf("vec%0d_busy_at_done", i), busy, 1);
    end

    // Both requests held from reset: 0, then 1, then 0 again; no grant
    // while busy, and each regrant lands in the IDLE cycle after DONE.
    exp_q[0] = 4'd15; exp_r[0] = 4'd0; exp_id[0] = 1'b0;
    exp_q[1] = 4'd4;  exp_r[1] = 4'd2; exp_id[1] = 1'b1;
    exp_q[2] = 4'd15; exp_r[2] = 4'd0; exp_id[2] = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; a0 = 4'd15; b0 = 4'd1;
    req1 = 1'b1; a1 = 4'd14; b1 = 4'd3;
    begin
      int prev_done;
      prev_done = -1;
      for (int t = 0; t < 3; t++) begin
        int  g;
        int  dc;
        int  bad;
        bit  got;
        bit  fin;
        g = -1; dc = -1; bad = 0; got = 1'b0; fin = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          #1;
          if (gnt0 || gnt1) got = 1'b1;
          else @(negedge clk);
        end
        check($sformatf("rr%0d_gnt", t), {gnt1, gnt0}, exp_id[t] ? 2'b10 : 2'b01);
        g = cyc;
        if (t > 0) check($sformatf("rr%0d_regrant_cycle", t), g, prev_done + 1);
        for (int k = 0; k < 20 && !fin; k++) begin
          @(negedge clk);
          if (gnt0 || gnt1) bad++;
          if (done) begin
            fin = 1'b1;
            dc  = cyc;
          end
        end
        check($sformatf("rr%0d_latency", t), dc - g, 5);
        check($sformatf("rr%0d_quotient", t), quotient, exp_q[t]);
        check($sformatf("rr%0d_remainder", t), remainder, exp_r[t]);
        check($sformatf("rr%0d_done_id", t), done_id, exp_id[t]);
        check($sformatf("rr%0d_no_gnt_busy", t), bad, 0);
        prev_done = dc;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Reset at RUN step 2: abort, clear outputs, no done, rr pointer back to 0.
    req0 = 1'b0; req1 = 1'b0;
    begin
      bit got;
      int nd;
      got = 1'b0;
      nd  = 0;
      req0 = 1'b1; a0 = 4'd13; b0 = 4'd3;
      for (int k = 0; k < 20 && !got; k++) begin
        #1;
        if (gnt0 || gnt1) got = 1'b1;
        else @(negedge clk);
      end
      check("abort_gnt0", gnt0, 1);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b1; a1 = 4'd6; b1 = 4'd2;
      @(negedge clk);
      check("run_req1_ignored", gnt1, 0);
      check("run_busy", busy, 1);
      @(negedge clk);
      check("run_hold_quotient", quotient, 15);
      rst = 1'b1;
      req1 = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_div_zero", div_zero, 0);
      check("abort_done_id", done_id, 0);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done) nd++;
      end
      check("abort_no_done", nd, 0);
      req0 = 1'b1; req1 = 1'b1;
      #1;
      check("abort_rr_favours0", {gnt1, gnt0}, 2'b01);
      @(posedge clk);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      check("abort_next_quotient", quotient, 4);
      check("abort_next_remainder", remainder, 1);
    end

    // Sweep all operand pairs against the reference, alternating requesters.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      logic [3:0] ea;
      logic [3:0] eb;
      logic [3:0] eq;
      logic [3:0] er;
      logic       edz;
      logic       sel;
      int         elat;
      ab  = 8'(i);
      ea  = ab[7:4];
      eb  = ab[3:0];
      sel = ab[0] ^ ab[4];
      if (eb == 4'd0) begin
        eq = 4'd15; er = ea; edz = 1'b1; elat = 1;
      end else begin
        eq = ea / eb; er = ea % eb; edz = 1'b0; elat = 5;
      end
      run_txn(sel, ea, eb, t_gok, t_lat, t_q, t_r, t_dz, t_id);
      check($sformatf("sweep_a%0d_b%0d", ea, eb),
            {t_gok, t_id, t_dz, t_q, t_r, 8'(t_lat)},
            {1'b1, sel, edz, eq, er, 8'(elat)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
